pipe_ctrl: RTL and testbench

//  Pipeline scheduler for the 5-stage core (IF/ID/EX/MEM/WB). Tracks in-flight

---
 rtl/pipe_ctrl.sv | 179 +++++++++++++++++
 tb/tb_pipe_ctrl.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline scheduler for the 5-stage IF/ID/EX/MEM/WB core.
// It tracks in-flight destination registers in a small scoreboard and stalls
// IF/ID on RAW hazards. On a taken jump or branch resolved in EX it flushes
// IF/ID and ID/EX and redirects the PC.
// Optional feature macro: PIPE_CTRL_BYPASS_EN. When it is defined, forwarding
// paths exist and only a load-use dependence on the EX entry stalls. When it is
// undefined, any source match with the EX or MEM entry stalls.
//
// Handshake/priority contract, evaluated each cycle:
//   ext_pause > ex_jump > flush window > RAW hazard > normal issue.
//   An ID instruction issues into EX at the next edge only when id_valid=1 and
//   no stall or flush is active and ext_pause=0.
//   While ext_pause=1 every register in this block holds its value.
//
// Flush timing: the cycle in which ex_jump is seen is the first flush cycle.
// pc_redirect is asserted in that cycle, and pc_target follows ex_jump_addr
// combinationally. The FLUSH state then carries FLUSH_CYCLES-1 further flush
// cycles. A FLUSH cycle whose counter has reached 0 behaves exactly like RUN.

`ifndef REG_ADDR
`define REG_ADDR 4:0
`endif
`ifndef XLEN_WIDTH
`define XLEN_WIDTH 31:0
`endif

module pipe_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               id_valid,
  input  logic [`REG_ADDR]   id_rs1,
  input  logic [`REG_ADDR]   id_rs2,
  input  logic               id_rs1_used,
  input  logic               id_rs2_used,
  input  logic [`REG_ADDR]   id_rd,
  input  logic               id_rd_we,
  input  logic               id_is_load,
  input  logic               ex_jump,
  input  logic [`XLEN_WIDTH] ex_jump_addr,
  input  logic               ext_pause,
  output logic               pause_if,
  output logic               pause_id,
  output logic               bubble_ex,
  output logic               flush_if,
  output logic               pc_redirect,
  output logic [`XLEN_WIDTH] pc_target,
  output logic               hazard_stall,
  output logic [1:0]         dbg_state,
  output logic [2:0]         dbg_sb_v,
  output logic [2:0]         dbg_sb_ld,
  output logic [2:0][`REG_ADDR] dbg_sb_rd
);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_HAZARD = 2'd1,
    ST_FLUSH  = 2'd2
  } state_t;

  typedef struct packed {
    logic             v;
    logic [`REG_ADDR] rd;
    logic             ld;
  } sb_entry_t;

  localparam logic [2:0] CNT_INIT = 3'(FLUSH_CYCLES - 1);

  state_t              state_q, state_d;
  logic [2:0]          cnt_q, cnt_d;
  logic [`XLEN_WIDTH]  target_q, target_d;
  sb_entry_t           sb_ex_q, sb_ex_d;
  sb_entry_t           sb_mem_q, sb_mem_d;
  sb_entry_t           sb_wb_q, sb_wb_d;
  logic                hazard;
  logic                flush_busy;
  logic                issue;

  // A source operand matches an in-flight entry (x0 and unused sources never match).
  function automatic logic src_hit(input logic used, input logic [`REG_ADDR] rs,
                                   input sb_entry_t e);
    return used && (rs != '0) && e.v && (e.rd == rs);
  endfunction

  // RAW hazard for the ID instruction. WB never hazards because the regfile is write-first.
  always_comb begin
    hazard = 1'b0;
`ifdef PIPE_CTRL_BYPASS_EN
    hazard = id_valid && sb_ex_q.ld &&
             (src_hit(id_rs1_used, id_rs1, sb_ex_q) || src_hit(id_rs2_used, id_rs2, sb_ex_q));
`else
    hazard = id_valid &&
             (src_hit(id_rs1_used, id_rs1, sb_ex_q)  || src_hit(id_rs2_used, id_rs2, sb_ex_q) ||
              src_hit(id_rs1_used, id_rs1, sb_mem_q) || src_hit(id_rs2_used, id_rs2, sb_mem_q));
`endif
  end

  assign flush_busy = (state_q == ST_FLUSH) && (cnt_q != 3'd0);

  // Next-state and output decode; outputs are forced to 0 while reset is asserted.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    target_d     = target_q;
    pause_if     = 1'b0;
    pause_id     = 1'b0;
    bubble_ex    = 1'b0;
    flush_if     = 1'b0;
    pc_redirect  = 1'b0;
    hazard_stall = 1'b0;
    pc_target    = target_q;
    issue        = 1'b0;
    if (!rst_n) begin
      pc_target = '0;
    end else if (ext_pause) begin
      pause_if = 1'b1;
      pause_id = 1'b1;
    end else if (ex_jump) begin
      flush_if    = 1'b1;
      bubble_ex   = 1'b1;
      pc_redirect = 1'b1;
      pc_target   = ex_jump_addr;
      target_d    = ex_jump_addr;
      state_d     = ST_FLUSH;
      cnt_d       = CNT_INIT;
    end else if (flush_busy) begin
      flush_if  = 1'b1;
      bubble_ex = 1'b1;
      cnt_d     = cnt_q - 3'd1;
    end else if (hazard) begin
      pause_if     = 1'b1;
      pause_id     = 1'b1;
      bubble_ex    = 1'b1;
      hazard_stall = 1'b1;
      state_d      = ST_HAZARD;
    end else begin
      state_d = ST_RUN;
      issue   = id_valid;
    end
  end

  // Scoreboard shift; everything holds while the pipeline is externally paused.
  always_comb begin
    sb_ex_d  = sb_ex_q;
    sb_mem_d = sb_mem_q;
    sb_wb_d  = sb_wb_q;
    if (!ext_pause) begin
      sb_wb_d  = sb_mem_q;
      sb_mem_d = sb_ex_q;
      sb_ex_d  = '{v: issue && id_rd_we && (id_rd != '0), rd: id_rd, ld: id_is_load};
    end
  end

  // State, counter, redirect target and scoreboard registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_RUN;
      cnt_q    <= 3'd0;
      target_q <= '0;
      sb_ex_q  <= '0;
      sb_mem_q <= '0;
      sb_wb_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      target_q <= target_d;
      sb_ex_q  <= sb_ex_d;
      sb_mem_q <= sb_mem_d;
      sb_wb_q  <= sb_wb_d;
    end
  end

  assign dbg_state = state_q;
  assign dbg_sb_v  = {sb_wb_q.v, sb_mem_q.v, sb_ex_q.v};
  assign dbg_sb_ld = {sb_wb_q.ld, sb_mem_q.ld, sb_ex_q.ld};
  assign dbg_sb_rd = {sb_wb_q.rd, sb_mem_q.rd, sb_ex_q.rd};

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed scenarios followed by random traffic for pipe_ctrl.
// Every cycle is compared against a reference model that keeps a history queue
// of the instructions issued toward EX. The model applies the scheduling rules
// directly: priority order, stall on source match, and a flush-cycles-remaining
// count.
module tb_pipe_ctrl;
  localparam int FC = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid, id_rs1_used, id_rs2_used, id_rd_we, id_is_load;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic        ex_jump, ext_pause;
  logic [31:0] ex_jump_addr;
  logic        pause_if, pause_id, bubble_ex, flush_if, pc_redirect, hazard_stall;
  logic [31:0] pc_target;
  logic [1:0]  dbg_state;
  logic [2:0]  dbg_sb_v, dbg_sb_ld;
  logic [2:0][4:0] dbg_sb_rd;

  // clock / reset
  always #5 clk = ~clk;

  pipe_ctrl #(.FLUSH_CYCLES(FC)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_rd(id_rd),
    .id_rd_we(id_rd_we), .id_is_load(id_is_load), .ex_jump(ex_jump),
    .ex_jump_addr(ex_jump_addr), .ext_pause(ext_pause), .pause_if(pause_if),
    .pause_id(pause_id), .bubble_ex(bubble_ex), .flush_if(flush_if),
    .pc_redirect(pc_redirect), .pc_target(pc_target), .hazard_stall(hazard_stall),
    .dbg_state(dbg_state), .dbg_sb_v(dbg_sb_v), .dbg_sb_ld(dbg_sb_ld), .dbg_sb_rd(dbg_sb_rd)
  );

  // reference model state
  typedef struct packed { logic v; logic [4:0] rd; logic ld; } ent_t;
  ent_t        hist[$];     // hist[0] = most recently issued slot (EX), hist[1] = MEM
  int          flush_left;
  logic [31:0] tgt;

  // scoreboard of expected values for the current cycle
  logic [5:0]  exp_q[$];    // {pause_if,pause_id,bubble_ex,flush_if,pc_redirect,hazard_stall}
  logic [31:0] exp_tgt;
  logic        exp_issue;
  logic [5:0]  last_ctl;
  logic [31:0] last_tgt;
  int          checks = 0;
  int          failures = 0;
  int          dut_stalls = 0;
  int          s0, n;

`ifdef PIPE_CTRL_BYPASS_EN
  localparam int ALU_DEP_STALLS  = 0;
  localparam int LOAD_DEP_STALLS = 1;
`else
  localparam int ALU_DEP_STALLS  = 2;
  localparam int LOAD_DEP_STALLS = 2;
`endif

  function automatic logic src_hit(input logic used, input logic [4:0] rs);
    if (!used || rs == 5'd0) return 1'b0;
`ifdef PIPE_CTRL_BYPASS_EN
    return hist[0].v && hist[0].ld && hist[0].rd == rs;
`else
    for (int i = 0; i < 2; i++) if (hist[i].v && hist[i].rd == rs) return 1'b1;
    return 1'b0;
`endif
  endfunction

  function automatic void model_reset();
    hist = {ent_t'(0), ent_t'(0), ent_t'(0)};
    flush_left = 0;
    tgt = '0;
  endfunction

  function automatic void model_eval();
    logic haz;
    logic [5:0] c;
    c = 6'b000000;
    exp_tgt = tgt;
    exp_issue = 1'b0;
    if (!rst_n) begin
      exp_tgt = '0;
    end else begin
      haz = id_valid && (src_hit(id_rs1_used, id_rs1) || src_hit(id_rs2_used, id_rs2));
      if (ext_pause) c = 6'b110000;
      else if (ex_jump) begin c = 6'b001110; exp_tgt = ex_jump_addr; end
      else if (flush_left > 0) c = 6'b001100;
      else if (haz) c = 6'b111001;
      else exp_issue = id_valid;
    end
    exp_q.push_back(c);
  endfunction

  function automatic void model_edge();
    ent_t e;
    if (!rst_n) begin model_reset(); return; end
    if (ext_pause) return;
    e.v  = exp_issue && id_rd_we && (id_rd != 5'd0);
    e.rd = id_rd;
    e.ld = id_is_load;
    hist.push_front(e);
    void'(hist.pop_back());
    if (ex_jump) begin flush_left = FC - 1; tgt = ex_jump_addr; end
    else if (flush_left > 0) flush_left--;
  endfunction

  // driver: one cycle with the currently applied inputs, checked at the falling edge
  task automatic step();
    logic [5:0] e;
    model_eval();
    @(negedge clk);
    e = exp_q.pop_front();
    last_ctl = {pause_if, pause_id, bubble_ex, flush_if, pc_redirect, hazard_stall};
    last_tgt = pc_target;
    checks++;
    assert (last_ctl === e) else begin
      failures++;
      $error("FAIL ctl t=%0t obs=%b exp=%b", $time, last_ctl, e);
    end
    checks++;
    assert (last_tgt === exp_tgt) else begin
      failures++;
      $error("FAIL pc_target t=%0t obs=%h exp=%h", $time, last_tgt, exp_tgt);
    end
    if (hazard_stall === 1'b1) dut_stalls++;
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int cycles);
    id_valid = 0; id_rd_we = 0; id_is_load = 0; id_rs1_used = 0; id_rs2_used = 0;
    ex_jump = 0; ext_pause = 0;
    repeat (cycles) step();
  endtask

  task automatic set_inst(input logic [4:0] rd, input logic we, input logic ld,
                          input logic [4:0] rs1, input logic u1,
                          input logic [4:0] rs2, input logic u2);
    id_valid = 1; id_rd = rd; id_rd_we = we; id_is_load = ld;
    id_rs1 = rs1; id_rs1_used = u1; id_rs2 = rs2; id_rs2_used = u2;
  endtask

  // hold an instruction in ID until the model says it issued (bounded)
  task automatic send(input logic [4:0] rd, input logic we, input logic ld,
                      input logic [4:0] rs1, input logic u1,
                      input logic [4:0] rs2, input logic u2);
    int k;
    k = 0;
    set_inst(rd, we, ld, rs1, u1, rs2, u2);
    do begin step(); k++; end while (!exp_issue && k < 20);
    checks++;
    assert (exp_issue) else begin
      failures++;
      $error("FAIL issue_timeout rd=%0d obs=not_issued exp=issued", rd);
    end
    id_valid = 0;
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 0; ex_jump_addr = '0; id_rd = '0; id_rs1 = '0; id_rs2 = '0;
    id_valid = 0; id_rd_we = 0; id_is_load = 0; id_rs1_used = 0; id_rs2_used = 0;
    ex_jump = 0; ext_pause = 0;
    model_reset();
    step();
    step();
    rst_n = 1;
    idle(2);

    // reset asserted in the middle of a RAW stall
    send(5'd11, 1, 1, 5'd2, 1, 5'd0, 0);
    set_inst(5'd12, 1, 0, 5'd11, 1, 5'd11, 1);
    step();
    check_int("stall_before_reset", int'(last_ctl), int'(6'b111001));
    rst_n = 0;
    step();
    check_int("outputs_in_reset", int'({last_ctl, last_tgt}), 0);
    rst_n = 1;
    #0;
    check_int("sb_empty_after_reset", int'(dbg_sb_v), 0);
    s0 = dut_stalls;
    send(5'd12, 1, 0, 5'd11, 1, 5'd11, 1);
    check_int("no_stall_after_reset", dut_stalls - s0, 0);
    idle(3);

    // ALU dependence: add x5; add x6,x5,x1
    send(5'd5, 1, 0, 5'd1, 1, 5'd2, 1);
    s0 = dut_stalls;
    send(5'd6, 1, 0, 5'd5, 1, 5'd1, 1);
    check_int("alu_dep_stalls", dut_stalls - s0, ALU_DEP_STALLS);
    idle(3);

    // load-use: lw x7,0(x2); add x8,x7,x7
    send(5'd7, 1, 1, 5'd2, 1, 5'd0, 0);
    s0 = dut_stalls;
    send(5'd8, 1, 0, 5'd7, 1, 5'd7, 1);
    check_int("load_use_stalls", dut_stalls - s0, LOAD_DEP_STALLS);
    idle(3);

    // jump from EX while ID is stalled
    send(5'd3, 1, 1, 5'd2, 1, 5'd0, 0);
    set_inst(5'd4, 1, 0, 5'd3, 1, 5'd0, 0);
    step();
    check_int("hazard_before_jump", int'(last_ctl), int'(6'b111001));
    ex_jump = 1; ex_jump_addr = 32'h80;
    step();
    check_int("jump_ctl", int'(last_ctl), int'(6'b001110));
    check_int("jump_target", int'(last_tgt), 32'h80);
    ex_jump = 0; ex_jump_addr = 32'h1234; id_valid = 0;
    n = 1;
    for (int i = 0; i < FC - 1; i++) begin
      step();
      if (last_ctl[3:2] === 2'b11) n++;
    end
    check_int("flush_cycles", n, FC);
    s0 = dut_stalls;
    send(5'd9, 1, 0, 5'd4, 1, 5'd4, 1);
    check_int("stalled_inst_dropped", dut_stalls - s0, 0);
    check_int("target_held", int'(last_tgt), 32'h80);
    idle(3);

    // external pause for 3 cycles with a pending load-use hazard
    send(5'd9, 1, 1, 5'd2, 1, 5'd0, 0);
    set_inst(5'd10, 1, 0, 5'd9, 1, 5'd9, 1);
    s0 = dut_stalls;
    step();
    ext_pause = 1;
    repeat (3) step();
    ext_pause = 0;
    n = 0;
    while (!exp_issue && n < 20) begin step(); n++; end
    id_valid = 0;
    check_int("pause_stall_count", dut_stalls - s0, LOAD_DEP_STALLS);
    idle(3);

    // x0 write then x0 reads back-to-back
    s0 = dut_stalls;
    send(5'd0, 1, 0, 5'd0, 1, 5'd0, 0);
    send(5'd1, 1, 0, 5'd0, 1, 5'd0, 1);
    check_int("x0_no_stall", dut_stalls - s0, 0);
    idle(2);

    // random traffic against the model
    for (int i = 0; i < 400; i++) begin
      id_valid    = ($urandom_range(0, 9) < 8);
      id_rd       = 5'($urandom_range(0, 3));
      id_rd_we    = $urandom_range(0, 1);
      id_is_load  = ($urandom_range(0, 3) == 0);
      id_rs1      = 5'($urandom_range(0, 3));
      id_rs2      = 5'($urandom_range(0, 3));
      id_rs1_used = $urandom_range(0, 1);
      id_rs2_used = $urandom_range(0, 1);
      ex_jump     = ($urandom_range(0, 9) == 0);
      ex_jump_addr = $urandom;
      ext_pause   = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 99) == 0) rst_n = 0;
      step();
      rst_n = 1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
